friscv_mem_arbiter: RTL
=======================

Name:
friscv_mem_arbiter

Overview:
- Shares one single-port synchronous SRAM (1-cycle read latency) between two requesters: the core's instruction-fetch port and its load/store port.
- Sits between friscv_top and a unified sram_4k instance. This lets code and data live in one memory.
- Priority is fixed to data, with a starvation guard that forces an instruction grant after a bounded run of data grants.
- Read data returns through an owner-tagged response pipeline.

Parameters:
- ADDR_WIDTH, 12: byte-address width presented to the SRAM.
- DATA_WIDTH, 32: word width.
- MAX_DSTREAK, 4: maximum consecutive data grants while an instruction request is waiting. Legal range 1..15.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset is synchronous and active-high.
- i_req_in  in  1  instruction-fetch request, read-only.
- i_addr_in  in  ADDR_WIDTH  fetch byte address.
- i_gnt_out  out  1  fetch request accepted this cycle.
- i_rvalid_out  out  1  fetch data valid.
- i_rdata_out  out  DATA_WIDTH  fetch data.
- d_req_in  in  1  data request.
- d_we_in  in  1  1 = write, 0 = read.
- d_addr_in  in  ADDR_WIDTH  data byte address.
- d_wdata_in  in  DATA_WIDTH  write data.
- d_gnt_out  out  1  data request accepted this cycle.
- d_rvalid_out  out  1  data read valid; never asserted for writes.
- d_rdata_out  out  DATA_WIDTH  data read result.
- mem_addr_out  out  ADDR_WIDTH  SRAM address.
- mem_we_out  out  1  SRAM write enable.
- mem_wdata_out  out  DATA_WIDTH  SRAM write data.
- mem_rdata_in  in  DATA_WIDTH  SRAM read data, valid 1 cycle after address.

Behaviour:
- Handshake:
  - A requester holds req, addr, we and wdata stable until it sees gnt high in a cycle. The transfer happens in that cycle.
  - Grants are combinational from the current requests and the streak counter. At most one grant per cycle.
  - Back-to-back grants are allowed every cycle, with no idle cycles.
- Selection:
  - If only one requester is active, it is granted.
  - If both are active, data is granted unless streak == MAX_DSTREAK. In that case instruction is granted.
- Streak counter (4 bits):
  - Increments on a data grant while i_req_in = 1.
  - Clears on an instruction grant, or in any cycle with i_req_in = 0.
  - Saturates at MAX_DSTREAK.
- SRAM drive:
  - mem_addr_out is the granted requester's address.
  - mem_we_out = d_gnt_out & d_we_in.
  - mem_wdata_out = d_wdata_in.
  - With no grant: mem_addr_out holds its last value, mem_we_out = 0.
- Response pipeline:
  - A registered owner tag, with encodings NONE / INSTR / DATA, captures the grant type each cycle. A data write records NONE.
  - Next cycle, i_rvalid_out = (tag == INSTR) and d_rvalid_out = (tag == DATA).
  - The matching rdata output equals mem_rdata_in. The non-owning rdata output is driven to 0.
  - Latency from gnt to rvalid is exactly 1 cycle. This holds for back-to-back grants and alternating owners.
- Reset:
  - While rst = 1: all grants 0, mem_we_out 0, tag NONE, streak 0, mem_addr_out 0, both rvalid 0, both rdata 0.
  - Reset asserted in the cycle after a grant drops that response: no rvalid is issued.
  - Requests held across reset release are granted in the first cycle with rst = 0.
- Combinational-path rule: no path from mem_rdata_in to any grant.

Test Plan:
- Fetch alone:
  - Stimulus: i_req_in = 1, i_addr_in = 0x010, SRAM word 0x00500093.
  - Response: i_gnt_out = 1 in cycle 0; i_rvalid_out = 1 with i_rdata_out = 0x00500093 in cycle 1; d_rvalid_out = 0.
- Data write then read:
  - Stimulus: write 0xDEADBEEF to 0x100 (d_we_in = 1), then read 0x100 on the next cycle.
  - Response: mem_we_out = 1 for 1 cycle only; no rvalid for the write; d_rvalid_out = 1 with 0xDEADBEEF one cycle after the read grant.
- Simultaneous single requests:
  - Stimulus: both requesting at cycle 0, streak = 0.
  - Response: d_gnt_out = 1 at cycle 0; i_gnt_out = 1 at cycle 1 (d_req_in dropped after its grant); rvalids at cycles 1 (data) and 2 (instr).
- Starvation guard:
  - Stimulus: MAX_DSTREAK = 4; i_req_in and d_req_in held high for 7 cycles.
  - Response: d_gnt_out in cycles 0–3, i_gnt_out in cycle 4, d_gnt_out in cycles 5–6; streak reads 0 after cycle 4.
- Reset mid-operation:
  - Stimulus: i_gnt_out in cycle 0, rst = 1 in cycle 1.
  - Response: i_rvalid_out = 0 in cycles 1–2, all outputs at reset values; a held i_req_in is granted in the first cycle after rst falls.
- Alternating pipelined reads:
  - Stimulus: i at 0x000, d at 0x200, i at 0x004 on consecutive cycles.
  - Response: rvalids alternate instr, data, instr in cycles 1–3, each carrying the correct word, with no cross-routing.

Source files
------------

// File: rtl/friscv_mem_arbiter.sv
// rtl/friscv_mem_arbiter.sv - fetch/data arbiter in front of a shared single-port SRAM
module friscv_mem_arbiter #(
  parameter int ADDR_WIDTH  = 12,
  parameter int DATA_WIDTH  = 32,
  parameter int MAX_DSTREAK = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req_in,
  input  logic [ADDR_WIDTH-1:0] i_addr_in,
  output logic                  i_gnt_out,
  output logic                  i_rvalid_out,
  output logic [DATA_WIDTH-1:0] i_rdata_out,
  input  logic                  d_req_in,
  input  logic                  d_we_in,
  input  logic [ADDR_WIDTH-1:0] d_addr_in,
  input  logic [DATA_WIDTH-1:0] d_wdata_in,
  output logic                  d_gnt_out,
  output logic                  d_rvalid_out,
  output logic [DATA_WIDTH-1:0] d_rdata_out,
  output logic [ADDR_WIDTH-1:0] mem_addr_out,
  output logic                  mem_we_out,
  output logic [DATA_WIDTH-1:0] mem_wdata_out,
  input  logic [DATA_WIDTH-1:0] mem_rdata_in
);

  typedef enum logic [1:0] {
    TAG_NONE  = 2'd0,
    TAG_INSTR = 2'd1,
    TAG_DATA  = 2'd2
  } tag_e;

  localparam logic [3:0] MaxStreak = 4'(MAX_DSTREAK);

  logic [3:0]            streak_q, streak_d;
  tag_e                  tag_q, tag_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  i_gnt, d_gnt;

  // Grant selection: data wins unless the fetch side has waited MAX_DSTREAK data grants.
  // Only requests and the streak feed this, never the SRAM read data.
  always_comb begin
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    if (!rst) begin
      if (d_req_in && !(i_req_in && (streak_q == MaxStreak))) begin
        d_gnt = 1'b1;
      end else if (i_req_in) begin
        i_gnt = 1'b1;
      end
    end
  end

  // Next-state for streak counter, owner tag and held SRAM address.
  always_comb begin
    streak_d = streak_q;
    tag_d    = TAG_NONE;
    addr_d   = addr_q;
    if (!i_req_in || i_gnt) begin
      streak_d = 4'd0;
    end else if (d_gnt && (streak_q != MaxStreak)) begin
      streak_d = streak_q + 4'd1;
    end
    if (i_gnt) begin
      tag_d  = TAG_INSTR;
      addr_d = i_addr_in;
    end else if (d_gnt) begin
      // Writes produce no read response, so they leave the tag at NONE.
      tag_d  = d_we_in ? TAG_NONE : TAG_DATA;
      addr_d = d_addr_in;
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      streak_q <= 4'd0;
      tag_q    <= TAG_NONE;
      addr_q   <= '0;
    end else begin
      streak_q <= streak_d;
      tag_q    <= tag_d;
      addr_q   <= addr_d;
    end
  end

  // Grant, SRAM drive and owner-routed response outputs. Reset masks a
  // response still in flight from the cycle before.
  always_comb begin
    i_gnt_out     = i_gnt;
    d_gnt_out     = d_gnt;
    mem_we_out    = d_gnt & d_we_in;
    mem_wdata_out = d_wdata_in;
    mem_addr_out  = rst ? '0 : addr_d;
    i_rvalid_out  = !rst && (tag_q == TAG_INSTR);
    d_rvalid_out  = !rst && (tag_q == TAG_DATA);
    i_rdata_out   = i_rvalid_out ? mem_rdata_in : '0;
    d_rdata_out   = d_rvalid_out ? mem_rdata_in : '0;
  end

endmodule
